// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multi-cycle multiply/divide
// sequencer (muldiv_seq).
//   state_t       FSM state encoding (IDLE / RUN / DONE)
//   OP_MUL/OP_DIV  values of the 'op' request bit
//   ALU_OP_ADD    ALU opcode driven at all times (add; subtract is done with invB+Cin)
//   MULDIV_ITERS  iterations per operation (one result bit per cycle)
//   DIVZERO_QUOT  quotient reported for a divide by zero
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic        OP_MUL       = 1'b0;
    localparam logic        OP_DIV       = 1'b1;
    localparam logic [2:0]  ALU_OP_ADD   = 3'b100;
    localparam int          MULDIV_ITERS = 16;
    localparam logic [15:0] DIVZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned 16x16 multiply (shift-add) and 16/16
// restoring divide. Has no adder of its own: each RUN cycle it drives the
// shared execute-stage ALU and consumes alu_Out / alu_Ofl in the same cycle.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, op           request (sampled in IDLE only); op 0=mul, 1=div
//   opA, opB            multiplier/dividend, multiplicand/divisor
//   busy                high in RUN and DONE
//   done                one-cycle pulse; res_* valid from this cycle on
//   res_hi, res_lo      product[31:16]/remainder, product[15:0]/quotient
//   div_zero            set with done for a divide by zero, held until next start
//   alu_A, alu_B        ALU operands (zero outside RUN)
//   alu_Op              ALU opcode, constant add
//   alu_Cin, alu_invA, alu_invB, alu_sign   ALU controls (zero outside RUN)
//   alu_Out, alu_Ofl    ALU result and unsigned carry-out
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_Op,
    output logic             alu_Cin,
    output logic             alu_invA,
    output logic             alu_invB,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_Out,
    input  logic             alu_Ofl
);

    localparam int CW = $clog2(ITERS);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    // acc doubles as the partial remainder for divide; m doubles as divisor.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             div_zero_q, div_zero_d;

    logic             last_iter;
    logic             accept;
    logic             start_dz;
    logic [WIDTH-1:0] sh;
    logic             msb;

    assign last_iter = (cnt_q == CW'(ITERS - 1));
    assign accept    = (state_q == S_IDLE) && start;
    assign start_dz  = (op == OP_DIV) && (opB == '0);

    // Divide shifts the next dividend bit in before the trial subtract; the
    // bit shifted out of rem acts as a 17th remainder bit.
    assign sh  = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign msb = acc_q[WIDTH-1];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = start_dz ? S_DONE : S_RUN;
            S_RUN:  if (last_iter) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        alu_Op   = ALU_OP_ADD;
        alu_A    = '0;
        alu_B    = '0;
        alu_Cin  = 1'b0;
        alu_invA = 1'b0;
        alu_invB = 1'b0;
        alu_sign = 1'b0;
        if (state_q == S_RUN) begin
            if (op_q == OP_MUL) begin
                alu_A = acc_q;
                alu_B = m_q;
            end else begin
                // sh - d as sh + ~d + 1; carry-out means no borrow
                alu_A    = sh;
                alu_B    = m_q;
                alu_invB = 1'b1;
                alu_Cin  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        div_zero_d = div_zero_q;

        if (accept) begin
            op_d       = op;
            cnt_d      = '0;
            acc_d      = '0;
            q_d        = opA;
            m_d        = opB;
            div_zero_d = 1'b0;
            if (start_dz) begin
                res_lo_d   = DIVZERO_QUOT;
                res_hi_d   = opA;
                div_zero_d = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            cnt_d = last_iter ? '0 : cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
                // {acc,q} shifts right one bit; carry-out becomes acc msb
                if (q_q[0]) begin
                    acc_d = {alu_Ofl, alu_Out[WIDTH-1:1]};
                    q_d   = {alu_Out[0], q_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    q_d   = {acc_q[0], q_q[WIDTH-1:1]};
                end
            end else begin
                if (msb | alu_Ofl) begin
                    acc_d = alu_Out;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = sh;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
            end
            // Results are captured from the final iteration so nothing partial
            // ever reaches res_*.
            if (last_iter) begin
                res_hi_d = acc_d;
                res_lo_d = q_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign res_hi   = res_hi_q;
    assign res_lo   = res_lo_q;
    assign div_zero = div_zero_q;

endmodule
